// File: rtl/aes_pkg.sv
// Shared AES-128 key-schedule types, round constants and the S-box based
// key expansion step used by the key_expansion engine.
package aes_pkg;

  localparam int unsigned AES_ROUNDS = 10;

  typedef logic [3:0][31:0] aes_block_t;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_ENG,
    STORE,
    FINISH
  } key_ctl_state_t;

  localparam logic [31:0] RCON [1:10] = '{
    32'h01000000, 32'h02000000, 32'h04000000, 32'h08000000, 32'h10000000,
    32'h20000000, 32'h40000000, 32'h80000000, 32'h1b000000, 32'h36000000
  };

  localparam logic [127:0] SBOX_ROW [16] = '{
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sub_byte(input logic [7:0] b);
    logic [127:0] row;
    row = SBOX_ROW[b[7:4]];
    return row[8 * (15 - b[3:0]) +: 8];
  endfunction

  // Blocks are row-major (word 3 = state row 0); the schedule works on columns,
  // so transpose in, run one FIPS-197 step, transpose back.
  function automatic aes_block_t expand_key(input aes_block_t k, input logic [31:0] rcon);
    logic [31:0] w0, w1, w2, w3, t, n0, n1, n2, n3;
    aes_block_t o;
    w0 = {k[3][31:24], k[2][31:24], k[1][31:24], k[0][31:24]};
    w1 = {k[3][23:16], k[2][23:16], k[1][23:16], k[0][23:16]};
    w2 = {k[3][15:8],  k[2][15:8],  k[1][15:8],  k[0][15:8]};
    w3 = {k[3][7:0],   k[2][7:0],   k[1][7:0],   k[0][7:0]};
    t  = {sub_byte(w3[23:16]), sub_byte(w3[15:8]), sub_byte(w3[7:0]), sub_byte(w3[31:24])} ^ rcon;
    n0 = w0 ^ t;
    n1 = w1 ^ n0;
    n2 = w2 ^ n1;
    n3 = w3 ^ n2;
    o[3] = {n0[31:24], n1[31:24], n2[31:24], n3[31:24]};
    o[2] = {n0[23:16], n1[23:16], n2[23:16], n3[23:16]};
    o[1] = {n0[15:8],  n1[15:8],  n2[15:8],  n3[15:8]};
    o[0] = {n0[7:0],   n1[7:0],   n2[7:0],   n3[7:0]};
    return o;
  endfunction

endpackage

// File: rtl/key_expansion.sv
// Single-round AES-128 key expansion engine: accepts a key/rcon strobe, returns
// the next round key with a one-cycle valid, then rests one cycle before re-arming.
module key_expansion
  import aes_pkg::*;
(
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             new_key_in,
  input  logic [3:0][31:0] key_in,
  input  logic [31:0]      rcon_in,
  output logic             valid_out,
  output logic [3:0][31:0] expanded_key_out
);

  typedef enum logic [1:0] {
    WAIT_FOR_KEY,
    EXPAND,
    VALID,
    PAUSE
  } eng_state_t;

  eng_state_t  state_q, state_d;
  aes_block_t  key_q, out_q;
  logic [31:0] rcon_q;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= WAIT_FOR_KEY;
      key_q   <= '0;
      rcon_q  <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == WAIT_FOR_KEY && new_key_in) begin
        key_q  <= key_in;
        rcon_q <= rcon_in;
      end
      if (state_q == EXPAND) out_q <= expand_key(key_q, rcon_q);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      WAIT_FOR_KEY: if (new_key_in) state_d = EXPAND;
      EXPAND:       state_d = VALID;
      VALID:        state_d = PAUSE;
      PAUSE:        state_d = WAIT_FOR_KEY;
      default:      state_d = WAIT_FOR_KEY;
    endcase
  end

  assign valid_out        = (state_q == VALID);
  assign expanded_key_out = out_q;

endmodule

// File: rtl/key_schedule_controller.sv
// Runs the AES-128 key schedule on one key_expansion engine and keeps round keys
// 0..10 in a flop bank with a registered read port.
module key_schedule_controller
  import aes_pkg::*;
#(
  parameter int unsigned NUM_ROUNDS = AES_ROUNDS
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             start_in,
  input  logic [3:0][31:0] key_in,
  input  logic [3:0]       rk_addr_in,
  output logic [127:0]     rk_data_out,
  output logic             busy_out,
  output logic             done_out,
  output logic             schedule_valid_out
);

  localparam int unsigned BANK_DEPTH = NUM_ROUNDS + 1;
  localparam logic [3:0]  LAST_ROUND = 4'(NUM_ROUNDS);

  key_ctl_state_t state_q, state_d;
  logic [3:0]     round_q;
  aes_block_t     cur_key_q, lat_q;
  aes_block_t     bank_q [BANK_DEPTH];
  logic [127:0]   rk_data_q;
  logic           busy_q, sv_q;

  logic        eng_new_key, eng_valid;
  logic [31:0] eng_rcon;
  aes_block_t  eng_key;

  key_expansion u_engine (
    .clk_in           (clk_in),
    .rst_in           (~rst_n_in),
    .new_key_in       (eng_new_key),
    .key_in           (cur_key_q),
    .rcon_in          (eng_rcon),
    .valid_out        (eng_valid),
    .expanded_key_out (eng_key)
  );

  assign eng_rcon = (round_q >= 4'd1 && round_q <= LAST_ROUND) ? RCON[round_q] : '0;

  always_comb begin
    state_d     = state_q;
    eng_new_key = 1'b0;
    done_out    = 1'b0;
    case (state_q)
      IDLE:     if (start_in) state_d = ISSUE;
      ISSUE: begin
        eng_new_key = 1'b1;
        state_d     = WAIT_ENG;
      end
      WAIT_ENG: if (eng_valid) state_d = STORE;
      // STORE always sits between valid and the next strobe, keeping the
      // strobe clear of the engine's post-valid pause cycle.
      STORE:    state_d = (round_q == LAST_ROUND) ? FINISH : ISSUE;
      FINISH: begin
        done_out = 1'b1;
        state_d  = IDLE;
      end
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q   <= IDLE;
      round_q   <= '0;
      cur_key_q <= '0;
      lat_q     <= '0;
      busy_q    <= 1'b0;
      sv_q      <= 1'b0;
      rk_data_q <= '0;
      for (int unsigned i = 0; i < BANK_DEPTH; i++) bank_q[i] <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: if (start_in) begin
          bank_q[0] <= key_in;
          cur_key_q <= key_in;
          round_q   <= 4'd1;
          busy_q    <= 1'b1;
          sv_q      <= 1'b0;
        end
        WAIT_ENG: if (eng_valid) lat_q <= eng_key;
        STORE: begin
          if (round_q <= LAST_ROUND) bank_q[round_q] <= lat_q;
          cur_key_q <= lat_q;
          if (round_q != LAST_ROUND) round_q <= round_q + 4'd1;
        end
        FINISH: begin
          busy_q <= 1'b0;
          sv_q   <= 1'b1;
        end
        default: ;
      endcase
      rk_data_q <= (rk_addr_in <= LAST_ROUND) ? bank_q[rk_addr_in] : '0;
    end
  end

  assign rk_data_out        = rk_data_q;
  assign busy_out           = busy_q;
  assign schedule_valid_out = sv_q;

endmodule
